// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
// Elastic pipeline-stage register with a valid/ready handshake on both sides,
// a synchronous flush that leaves a bubble behind, and an optional two-entry
// skid buffer that makes in_ready a pure register output.
module pipe_stage_skid #(
  parameter int            DW         = 64,
  parameter logic [DW-1:0] RESET_DATA = '0,
  parameter bit            SKID       = 1'b1,
  parameter int            CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] STALL_MAX = '1;

  logic [CNT_W-1:0] stall_cnt_reg;

  // Count cycles where downstream refuses a live word; saturates instead of
  // wrapping, and deliberately survives a flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_reg <= '0;
    end else if (out_valid && !out_ready && (stall_cnt_reg != STALL_MAX)) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_reg;

  generate
    if (SKID) begin : g_skid
      // M is the head entry driving the output, S catches the word that
      // arrives while M is blocked so in_ready never depends on out_ready.
      typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
      } state_t;

      state_t        state_reg, state_next;
      logic [DW-1:0] m_d_reg, m_d_next;
      logic [DW-1:0] s_d_reg, s_d_next;
      logic          in_ready_reg, in_ready_next;
      logic          out_valid_reg, out_valid_next;
      logic [1:0]    occ_reg, occ_next;
      logic          in_xfer, out_xfer;

      assign in_xfer  = in_valid && in_ready_reg;
      assign out_xfer = out_valid_reg && out_ready;

      // Next-state and datapath selection; flush overrides any transfer.
      always_comb begin
        state_next = state_reg;
        m_d_next   = m_d_reg;
        s_d_next   = s_d_reg;
        if (flush) begin
          state_next = ST_EMPTY;
          m_d_next   = RESET_DATA;
          s_d_next   = RESET_DATA;
        end else begin
          case (state_reg)
            ST_EMPTY: begin
              if (in_xfer) begin
                m_d_next   = in_data;
                state_next = ST_BUSY;
              end
            end
            ST_BUSY: begin
              if (in_xfer && out_xfer) begin
                m_d_next = in_data;
              end else if (in_xfer) begin
                s_d_next   = in_data;
                state_next = ST_FULL;
              end else if (out_xfer) begin
                state_next = ST_EMPTY;
              end
            end
            ST_FULL: begin
              if (out_xfer) begin
                m_d_next   = s_d_reg;
                state_next = ST_BUSY;
              end
            end
            default: begin
              state_next = ST_EMPTY;
            end
          endcase
        end
      end

      // Decode the handshake outputs from the upcoming state so they can be
      // registered alongside it rather than decoded after the flops.
      always_comb begin
        out_valid_next = (state_next != ST_EMPTY);
        in_ready_next  = (state_next != ST_FULL);
        case (state_next)
          ST_BUSY: occ_next = 2'd1;
          ST_FULL: occ_next = 2'd2;
          default: occ_next = 2'd0;
        endcase
      end

      // State, payload and registered handshake outputs.
      always_ff @(posedge clk) begin
        if (reset) begin
          state_reg     <= ST_EMPTY;
          m_d_reg       <= RESET_DATA;
          s_d_reg       <= RESET_DATA;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
          occ_reg       <= 2'd0;
        end else begin
          state_reg     <= state_next;
          m_d_reg       <= m_d_next;
          s_d_reg       <= s_d_next;
          in_ready_reg  <= in_ready_next;
          out_valid_reg <= out_valid_next;
          occ_reg       <= occ_next;
        end
      end

      assign in_ready  = in_ready_reg;
      assign out_valid = out_valid_reg;
      assign out_data  = m_d_reg;
      assign occupancy = occ_reg;
    end else begin : g_single
      // Single register: a new word may enter in the same cycle the held
      // one leaves, so in_ready looks through to out_ready.
      logic          m_v_reg, m_v_next;
      logic [DW-1:0] m_d_reg, m_d_next;
      logic          in_xfer, out_xfer;

      assign in_ready = !m_v_reg || out_ready;
      assign in_xfer  = in_valid && in_ready;
      assign out_xfer = m_v_reg && out_ready;

      // Load on accept, drop the valid bit on a drain without refill.
      always_comb begin
        m_v_next = m_v_reg;
        m_d_next = m_d_reg;
        if (flush) begin
          m_v_next = 1'b0;
          m_d_next = RESET_DATA;
        end else if (in_xfer) begin
          m_v_next = 1'b1;
          m_d_next = in_data;
        end else if (out_xfer) begin
          m_v_next = 1'b0;
        end
      end

      // Main register.
      always_ff @(posedge clk) begin
        if (reset) begin
          m_v_reg <= 1'b0;
          m_d_reg <= RESET_DATA;
        end else begin
          m_v_reg <= m_v_next;
          m_d_reg <= m_d_next;
        end
      end

      assign out_valid = m_v_reg;
      assign out_data  = m_d_reg;
      assign occupancy = {1'b0, m_v_reg};
    end
  endgenerate

endmodule
